instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Encodes LEGv8 instruction requests (mnemonic + register fields + immediate) into 32-bit words.
//  Writes them into instruction memory at consecutive word addresses; it is the program-loader
//  front end, the inverse of the main decoder. Covers the decoder's instruction set:
//  ADD SUB AND ORR LDUR STUR CBZ BR ERET MRS. Range checks immediates; illegal requests are
//  flagged and dropped.
// PARAMETERS
//  ADDR_W  8   byte-address width of wr_addr; must satisfy DEPTH*4 <= 2**ADDR_W
//  DEPTH   64  number of 32-bit instruction slots to be filled
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  clear       in   1       sync restart: slot counter to 0, drops pending word, clears err_sticky
//  in_valid    in   1       request valid
//  in_ready    out  1       block can accept; transfer = in_valid & in_ready
//  in_mnem     in   4       0 ADD 1 SUB 2 AND 3 ORR 4 LDUR 5 STUR 6 CBZ 7 BR 8 ERET 9 MRS; 10-15 invalid
//  in_rd       in   5       Rd / Rt
//  in_rn       in   5       Rn (also BR target)
//  in_rm       in   5       Rm
//  in_imm      in   19      signed imm (D: 9b DT_addr, CB: 19b), unsigned 16b sysreg (MRS)
//  wr_en       out  1       imem write strobe
//  wr_addr     out  ADDR_W  byte address = slot*4
//  wr_data     out  32      encoded instruction
//  err         out  1       1-cycle pulse: accepted request was illegal, not written
//  err_sticky  out  1       set by err, cleared by clear/reset
//  full        out  1       DEPTH slots consumed
//  count       out  $clog2(DEPTH)+1  slots consumed (accepted legal requests)
// BEHAVIOUR
//  Reset: wr_en=0, wr_addr=0, wr_data=0, err=0, err_sticky=0, full=0, count=0;
//    state LOAD. A pending write is discarded.
//  FSM: LOAD -(legal accept making count==DEPTH)-> FULL; FULL -(clear)-> LOAD; LOAD -(clear)-> LOAD.
//  in_ready = (state==LOAD) & ~clear (combinational). clear outranks a same-cycle in_valid.
//  Latency 1: a legal accept in cycle N gives wr_en=1 in N+1 with wr_addr=count_N*4; throughput 1/cycle.
//  count increments at accept, so full/in_ready drop in the cycle after the last slot is accepted.
//  Encoding (op = opcode bits):
//    R (ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550): op[31:21] Rm[20:16] shamt=0[15:10] Rn[9:5] Rd[4:0]
//    D (LDUR 0x7C2, STUR 0x7C0): op[31:21] imm9[20:12] 00[11:10] Rn[9:5] Rt[4:0]
//    CB (CBZ 0xB4): op8[31:24] imm19[23:5] Rt[4:0]
//    BR 0x6B0: op[31:21] 11111[20:16] 0[15:10] Rn[9:5] 0[4:0]
//    ERET: fixed word 0xD69F03E0; register and imm fields ignored
//    MRS 0x6A9: op[31:21] sysreg16[20:5] Rt[4:0]
//  Illegal: mnem>=10; D imm outside -256..255; MRS in_imm[18:16]!=0. Such a request is accepted
//    (handshake completes), then err=1 in N+1, wr_en=0 and count unchanged.
//  A clear during a pending write cycle does not suppress that write; the write already in flight
//    still lands at its address. Slot 0 is written next.
//  wr_data/wr_addr hold their last value when wr_en=0.
// STRUCTURE
//  legv8_pkg: mnemonic enum, 11-bit/8-bit opcode constants, ERET_WORD, format field widths.
//    Shared with the main decoder.
//  Sub-module instr_field_pack: combinational mnem+fields -> {word, illegal}. The top holds the
//    FSM, counter and output registers.
// TESTING
//  ADD rd=1 rn=2 rm=3 -> next cycle wr_en=1, wr_addr=0x00, wr_data=0x8B030041
//  LDUR rd=9 rn=22 imm=64 then CBZ rd=5 imm=-2 back-to-back -> 0xF84402C9 @0x00, 0xB4FFFFC5 @0x04
//  ERET with random fields -> 0xD69F03E0; MRS imm=0x1_0000 -> err pulse, err_sticky=1, no wr_en, count same
//  mnem=12 and LDUR imm=300 -> err each, count unchanged; next legal ADD lands at the next slot
//  DEPTH=4, 5 legal requests streamed -> 4 writes @0,4,8,12; full=1 and in_ready=0 after 4th accept;
//    5th held; clear -> LOAD, next write @0x00
//  reset asserted the cycle after an accept -> no wr_en, all outputs at reset values asynchronously

Source files
------------

// File: rtl/legv8_pkg.sv
// LEGv8 instruction-set constants shared by the encoder and the main decoder.
package legv8_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned MNEM_W   = 4;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned IMM_W    = 19;
    localparam int unsigned OP11_W   = 11;
    localparam int unsigned OP8_W    = 8;
    localparam int unsigned DT_W     = 9;
    localparam int unsigned SYSREG_W = 16;
    localparam int unsigned SHAMT_W  = 6;

    typedef enum logic [MNEM_W-1:0] {
        MN_ADD  = 4'd0,
        MN_SUB  = 4'd1,
        MN_AND  = 4'd2,
        MN_ORR  = 4'd3,
        MN_LDUR = 4'd4,
        MN_STUR = 4'd5,
        MN_CBZ  = 4'd6,
        MN_BR   = 4'd7,
        MN_ERET = 4'd8,
        MN_MRS  = 4'd9
    } mnem_e;

    localparam logic [OP11_W-1:0] OP_ADD  = 11'h458;
    localparam logic [OP11_W-1:0] OP_SUB  = 11'h658;
    localparam logic [OP11_W-1:0] OP_AND  = 11'h450;
    localparam logic [OP11_W-1:0] OP_ORR  = 11'h550;
    localparam logic [OP11_W-1:0] OP_LDUR = 11'h7C2;
    localparam logic [OP11_W-1:0] OP_STUR = 11'h7C0;
    localparam logic [OP11_W-1:0] OP_BR   = 11'h6B0;
    localparam logic [OP11_W-1:0] OP_MRS  = 11'h6A9;
    localparam logic [OP8_W-1:0]  OP_CBZ  = 8'hB4;

    localparam logic [INSTR_W-1:0] ERET_WORD  = 32'hD69F03E0;
    localparam logic [REG_W-1:0]   BR_RM_ONES = 5'b11111;

    // One encoder request as presented on the loader input.
    typedef struct packed {
        logic [MNEM_W-1:0] mnem;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rn;
        logic [REG_W-1:0]  rm;
        logic [IMM_W-1:0]  imm;
    } instr_req_t;

    // A 19-bit signed value fits DT_addr when every bit above the 9-bit field matches its sign.
    function automatic logic dt_in_range(input logic [IMM_W-1:0] imm);
        return (&imm[IMM_W-1:DT_W-1]) | ~(|imm[IMM_W-1:DT_W-1]);
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational LEGv8 field packer: request -> 32-bit instruction word plus illegal flag.
module instr_field_pack
    import legv8_pkg::*;
(
    input  instr_req_t         req,
    output logic [INSTR_W-1:0] word,
    output logic               illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (req.mnem)
            MN_ADD:  word = {OP_ADD, req.rm, SHAMT_W'(0), req.rn, req.rd};
            MN_SUB:  word = {OP_SUB, req.rm, SHAMT_W'(0), req.rn, req.rd};
            MN_AND:  word = {OP_AND, req.rm, SHAMT_W'(0), req.rn, req.rd};
            MN_ORR:  word = {OP_ORR, req.rm, SHAMT_W'(0), req.rn, req.rd};
            MN_LDUR: begin
                word    = {OP_LDUR, req.imm[DT_W-1:0], 2'b00, req.rn, req.rd};
                illegal = ~dt_in_range(req.imm);
            end
            MN_STUR: begin
                word    = {OP_STUR, req.imm[DT_W-1:0], 2'b00, req.rn, req.rd};
                illegal = ~dt_in_range(req.imm);
            end
            MN_CBZ:  word = {OP_CBZ, req.imm, req.rd};
            MN_BR:   word = {OP_BR, BR_RM_ONES, SHAMT_W'(0), req.rn, REG_W'(0)};
            MN_ERET: word = ERET_WORD;
            MN_MRS: begin
                // System register number is unsigned 16-bit; upper imm bits must be zero.
                word    = {OP_MRS, req.imm[SYSREG_W-1:0], req.rd};
                illegal = |req.imm[IMM_W-1:SYSREG_W];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program-loader front end: encodes LEGv8 requests and writes them to consecutive imem slots.
module instr_encoder
    import legv8_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [MNEM_W-1:0]        in_mnem,
    input  logic [REG_W-1:0]         in_rd,
    input  logic [REG_W-1:0]         in_rn,
    input  logic [REG_W-1:0]         in_rm,
    input  logic [IMM_W-1:0]         in_imm,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [INSTR_W-1:0]       wr_data,
    output logic                     err,
    output logic                     err_sticky,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_FULL = 1'b1
    } state_e;

    state_e             state;
    state_e             state_nx;
    instr_req_t         req;
    logic [INSTR_W-1:0] enc_word;
    logic               enc_illegal;
    logic               accept;
    logic               accept_legal;
    logic               last_slot;

    assign req = '{mnem: in_mnem, rd: in_rd, rn: in_rn, rm: in_rm, imm: in_imm};

    instr_field_pack u_pack (
        .req     (req),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign in_ready     = (state == S_LOAD) & ~clear;
    assign accept       = in_valid & in_ready;
    assign accept_legal = accept & ~enc_illegal;
    assign last_slot    = (count == CNT_W'(DEPTH - 1));
    assign full         = (state == S_FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_LOAD;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD: if (!clear && accept_legal && last_slot) state_nx = S_FULL;
            S_FULL: if (clear) state_nx = S_LOAD;
            default: state_nx = S_LOAD;
        endcase
    end

    // Write port, slot counter and error flags; address/data hold between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            count      <= '0;
        end else begin
            wr_en <= 1'b0;
            err   <= 1'b0;
            if (clear) begin
                count      <= '0;
                err_sticky <= 1'b0;
            end else if (accept) begin
                if (enc_illegal) begin
                    err        <= 1'b1;
                    err_sticky <= 1'b1;
                end else begin
                    wr_en   <= 1'b1;
                    wr_addr <= ADDR_W'({count, 2'b00});
                    wr_data <= enc_word;
                    count   <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table, directed corner sequences, random vs model.
module tb_instr_encoder;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_mnem = '0;
    logic [4:0]        in_rd = '0, in_rn = '0, in_rm = '0;
    logic [18:0]       in_imm = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              err, err_sticky, full;
    logic [CNT_W-1:0]  count;

    int checks = 0;
    int failures = 0;

    // reference model state
    int          m_count = 0;
    bit          m_full = 0, m_sticky = 0, m_wr_en = 0, m_err = 0;
    logic [31:0] m_addr = '0, m_data = '0;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .err(err), .err_sticky(err_sticky), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoding from the instruction-format rules using plain arithmetic.
    task automatic model_encode(input logic [3:0] mn, input logic [4:0] rd, input logic [4:0] rn,
                                input logic [4:0] rm, input logic [18:0] imm,
                                output logic [31:0] w, output bit ill);
        longint acc;
        int     s;
        s   = (int'(imm) >= 262144) ? int'(imm) - 524288 : int'(imm);
        acc = 0;
        ill = 0;
        case (int'(mn))
            0: acc = longint'('h458) * 2097152 + rm * 65536 + rn * 32 + rd;
            1: acc = longint'('h658) * 2097152 + rm * 65536 + rn * 32 + rd;
            2: acc = longint'('h450) * 2097152 + rm * 65536 + rn * 32 + rd;
            3: acc = longint'('h550) * 2097152 + rm * 65536 + rn * 32 + rd;
            4, 5: begin
                acc = longint'((mn == 4) ? 'h7C2 : 'h7C0) * 2097152
                      + ((s + 512) % 512) * 4096 + rn * 32 + rd;
                ill = (s < -256) || (s > 255);
            end
            6: acc = longint'('hB4) * 16777216 + ((s + 524288) % 524288) * 32 + rd;
            7: acc = longint'('h6B0) * 2097152 + 31 * 65536 + rn * 32;
            8: acc = longint'('hD69F03E0);
            9: begin
                acc = longint'('h6A9) * 2097152 + (int'(imm) % 65536) * 32 + rd;
                ill = (int'(imm) / 65536) != 0;
            end
            default: ill = 1;
        endcase
        w = 32'(acc);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".wr_en"},      32'(wr_en),      32'(m_wr_en));
        chk({tag, ".err"},        32'(err),        32'(m_err));
        chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
        chk({tag, ".full"},       32'(full),       32'(m_full));
        chk({tag, ".count"},      32'(count),      32'(m_count));
        chk({tag, ".wr_addr"},    32'(wr_addr),    m_addr);
        chk({tag, ".wr_data"},    wr_data,         m_data);
    endtask

    // One clock cycle: drive inputs, check ready, advance model, check registered outputs.
    task automatic cycle(input string tag, input bit v, input bit clr, input logic [3:0] mn,
                         input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                         input logic [18:0] imm);
        bit          rdy, ill;
        logic [31:0] w;
        in_valid = v; clear = clr; in_mnem = mn;
        in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
        #1;
        rdy = !m_full && !clr;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        model_encode(mn, rd, rn, rm, imm, w, ill);
        m_wr_en = 0;
        m_err   = 0;
        if (clr) begin
            m_count = 0; m_full = 0; m_sticky = 0;
        end else if (v && rdy) begin
            if (ill) begin
                m_err = 1; m_sticky = 1;
            end else begin
                m_wr_en = 1;
                m_addr  = 32'(m_count * 4);
                m_data  = w;
                m_count++;
                if (m_count == DEPTH) m_full = 1;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
        in_valid = 0; clear = 0;
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 19'd0);
    endtask

    task automatic do_clear(input string tag);
        cycle(tag, 0, 1, 4'd0, 5'd0, 5'd0, 5'd0, 19'd0);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  mnem;
        logic [4:0]  rd, rn, rm;
        logic [18:0] imm;
        logic [31:0] exp_word;
        bit          exp_ill;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"add",      4'd0,  5'd1,  5'd2,  5'd3,  19'd0,      32'h8B030041, 1'b0});
        vecs.push_back('{"sub",      4'd1,  5'd0,  5'd31, 5'd31, 19'd5,      32'hCB1F03E0, 1'b0});
        vecs.push_back('{"and",      4'd2,  5'd4,  5'd5,  5'd6,  19'd0,      32'h8A0600A4, 1'b0});
        vecs.push_back('{"orr",      4'd3,  5'd31, 5'd0,  5'd1,  19'd0,      32'hAA01001F, 1'b0});
        vecs.push_back('{"ldur64",   4'd4,  5'd9,  5'd22, 5'd0,  19'd64,     32'hF84402C9, 1'b0});
        vecs.push_back('{"stur_min", 4'd5,  5'd2,  5'd3,  5'd0,  19'h7FF00,  32'hF8100062, 1'b0});
        vecs.push_back('{"ldur_max", 4'd4,  5'd0,  5'd0,  5'd0,  19'd255,    32'hF84FF000, 1'b0});
        vecs.push_back('{"ldur_300", 4'd4,  5'd1,  5'd1,  5'd1,  19'd300,    32'h0,        1'b1});
        vecs.push_back('{"ldur_m257",4'd4,  5'd1,  5'd1,  5'd1,  19'h7FEFF,  32'h0,        1'b1});
        vecs.push_back('{"cbz_m2",   4'd6,  5'd5,  5'd0,  5'd0,  19'h7FFFE,  32'hB4FFFFC5, 1'b0});
        vecs.push_back('{"cbz_max",  4'd6,  5'd0,  5'd9,  5'd9,  19'h3FFFF,  32'hB47FFFE0, 1'b0});
        vecs.push_back('{"br",       4'd7,  5'd5,  5'd30, 5'd7,  19'd77,     32'hD61F03C0, 1'b0});
        vecs.push_back('{"eret",     4'd8,  5'd7,  5'd9,  5'd3,  19'd123,    32'hD69F03E0, 1'b0});
        vecs.push_back('{"mrs",      4'd9,  5'd3,  5'd0,  5'd0,  19'h0C082,  32'hD5381043, 1'b0});
        vecs.push_back('{"mrs_bad",  4'd9,  5'd3,  5'd0,  5'd0,  19'h10000,  32'h0,        1'b1});
        vecs.push_back('{"mnem10",   4'd10, 5'd1,  5'd2,  5'd3,  19'd0,      32'h0,        1'b1});
        vecs.push_back('{"mnem12",   4'd12, 5'd1,  5'd2,  5'd3,  19'd0,      32'h0,        1'b1});
        vecs.push_back('{"mnem15",   4'd15, 5'd1,  5'd2,  5'd3,  19'd0,      32'h0,        1'b1});

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;

        // table vectors, each from a cleared slot counter
        foreach (vecs[i]) begin
            do_clear("tbl.clr");
            cycle(vecs[i].name, 1, 0, vecs[i].mnem, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm);
            chk({vecs[i].name, ".tbl_err"}, 32'(err), 32'(vecs[i].exp_ill));
            chk({vecs[i].name, ".tbl_wen"}, 32'(wr_en), 32'(!vecs[i].exp_ill));
            if (!vecs[i].exp_ill) begin
                chk({vecs[i].name, ".tbl_data"}, wr_data, vecs[i].exp_word);
                chk({vecs[i].name, ".tbl_addr"}, 32'(wr_addr), 32'h0);
            end
        end

        // back-to-back LDUR then CBZ
        do_clear("b2b.clr");
        cycle("b2b.ldur", 1, 0, 4'd4, 5'd9, 5'd22, 5'd0, 19'd64);
        chk("b2b.ldur_word", wr_data, 32'hF84402C9);
        chk("b2b.ldur_addr", 32'(wr_addr), 32'h00);
        cycle("b2b.cbz", 1, 0, 4'd6, 5'd5, 5'd0, 5'd0, 19'h7FFFE);
        chk("b2b.cbz_word", wr_data, 32'hB4FFFFC5);
        chk("b2b.cbz_addr", 32'(wr_addr), 32'h04);

        // illegal requests do not consume slots
        do_clear("ill.clr");
        cycle("ill.add0", 1, 0, 4'd0, 5'd1, 5'd2, 5'd3, 19'd0);
        cycle("ill.m12",  1, 0, 4'd12, 5'd1, 5'd2, 5'd3, 19'd0);
        cycle("ill.ld300",1, 0, 4'd4, 5'd1, 5'd2, 5'd3, 19'd300);
        chk("ill.count", 32'(count), 32'd1);
        chk("ill.sticky", 32'(err_sticky), 32'd1);
        cycle("ill.add1", 1, 0, 4'd0, 5'd1, 5'd2, 5'd3, 19'd0);
        chk("ill.next_addr", 32'(wr_addr), 32'h04);

        // fill all slots, extra request held, clear restarts at slot 0
        do_clear("fill.clr");
        for (int i = 0; i < 5; i++)
            cycle("fill.req", 1, 0, 4'd1, 5'(i), 5'd2, 5'd3, 19'd0);
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.count", 32'(count), 32'(DEPTH));
        chk("fill.last_addr", 32'(wr_addr), 32'h0C);
        cycle("fill.held", 1, 0, 4'd1, 5'd7, 5'd2, 5'd3, 19'd0);
        do_clear("fill.clr2");
        cycle("fill.after", 1, 0, 4'd0, 5'd4, 5'd4, 5'd4, 19'd0);
        chk("fill.restart_addr", 32'(wr_addr), 32'h00);

        // clear while a write is on the port: write stays, next lands at slot 0
        cycle("pend.add", 1, 0, 4'd0, 5'd8, 5'd8, 5'd8, 19'd0);
        chk("pend.wen", 32'(wr_en), 32'd1);
        do_clear("pend.clr");
        cycle("pend.next", 1, 0, 4'd3, 5'd1, 5'd1, 5'd1, 19'd0);
        chk("pend.next_addr", 32'(wr_addr), 32'h00);

        // randomized against the model
        for (int n = 0; n < 400; n++) begin
            logic [18:0] imm;
            case ($urandom_range(0, 2))
                0: imm = 19'($urandom);
                1: imm = 19'(int'($urandom_range(0, 600)) - 300);
                default: imm = 19'($urandom_range(0, 65535));
            endcase
            cycle("rnd", $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                  4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom), imm);
        end

        // asynchronous reset right after an accept
        do_clear("rst.clr");
        cycle("rst.add0", 1, 0, 4'd0, 5'd1, 5'd2, 5'd3, 19'd0);
        cycle("rst.add1", 1, 0, 4'd2, 5'd6, 5'd7, 5'd8, 19'd0);
        #2;
        reset = 1;
        m_count = 0; m_full = 0; m_sticky = 0; m_wr_en = 0; m_err = 0;
        m_addr = '0; m_data = '0;
        #1;
        check_outputs("rst.async");
        @(posedge clk);
        #1;
        check_outputs("rst.hold");
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        cycle("rst.after", 1, 0, 4'd0, 5'd1, 5'd2, 5'd3, 19'd0);
        chk("rst.after_addr", 32'(wr_addr), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
